// File: rtl/ffd_bank_write_arbiter.sv
// Purpose : round-robin arbiter + one-shot write sequencer for a bank of D registers.
// Latency : grant 1 cycle after req sampled in IDLE, bank_ld the cycle after, ack one later.
// Backpr. : requesters hold req until ack; others stay pending and compete at next IDLE.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req   [NREQ]         per-requester request, held until its ack
//   i_addr  [NREQ*AW]      requester i target address at [i*AW +: AW]
//   i_wdata [NREQ*DW]      requester i write data at [i*DW +: DW]
//   o_grant [NREQ]         one-hot current owner, zero when idle
//   o_ack   [NREQ]         one-cycle pulse to the owner once its write is done
//   o_bank_ld [2**AW]      one-hot load enable into the register bank
//   o_bank_d  [DW]         data for the bank d inputs (holds last value)
//   o_busy                 high whenever the sequencer is not idle
//   o_err                  sticky release-timeout flag
// Build option: define FFD_ARB_TIMEOUT_EN to bound the RELEASE wait to TOUT cycles;
// otherwise RELEASE waits indefinitely and o_err is constant 0.
module ffd_bank_write_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8,
    parameter int TOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*AW-1:0]   i_addr,
    input  logic [NREQ*DW-1:0]   i_wdata,
    output logic [NREQ-1:0]      o_grant,
    output logic [NREQ-1:0]      o_ack,
    output logic [(1<<AW)-1:0]   o_bank_ld,
    output logic [DW-1:0]        o_bank_d,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int DEPTH = 1 << AW;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_RELEASE} state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr, w_ptr_nxt;
    logic [PW-1:0]     r_win, w_win_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [DW-1:0]     r_data, w_data_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic [NREQ-1:0]   r_ack, w_ack_nxt;
    logic [DEPTH-1:0]  r_ld, w_ld_nxt;
    logic [DW-1:0]     r_d, w_d_nxt;
    logic              r_busy;

    logic              w_found;
    logic [PW-1:0]     w_pick;

`ifdef FFD_ARB_TIMEOUT_EN
    localparam logic [4:0] TLIM = 5'(TOUT - 1);
    logic [4:0]        r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
`endif

    // (base + k) mod NREQ without a divider; k is always < NREQ here.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // First asserted request searching from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_ptr, k);
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered, so each
    // state's effect appears on the pins in the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_ld_nxt    = '0;
        w_d_nxt     = r_d;
`ifdef FFD_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    // Capture the winner's address/data now; later changes are ignored.
                    w_win_nxt   = w_pick;
                    w_addr_nxt  = i_addr[w_pick*AW +: AW];
                    w_data_nxt  = i_wdata[w_pick*DW +: DW];
                    w_grant_nxt = NREQ'(1) << w_pick;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld_nxt    = DEPTH'(1) << r_addr;
                w_d_nxt     = r_data;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_ack_nxt   = NREQ'(1) << r_win;
                w_state_nxt = S_RELEASE;
`ifdef FFD_ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            S_RELEASE: begin
                if (!i_req[r_win]) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = wrap_add(r_win, 1);
                end
`ifdef FFD_ARB_TIMEOUT_EN
                else if (r_cnt == TLIM) begin
                    // Owner never released: abandon it and move the pointer past it.
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = wrap_add(r_win, 1);
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_ld    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
`ifdef FFD_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_ld    <= w_ld_nxt;
            r_d     <= w_d_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
`ifdef FFD_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign o_grant   = r_grant;
    assign o_ack     = r_ack;
    assign o_bank_ld = r_ld;
    assign o_bank_d  = r_d;
    assign o_busy    = r_busy;
`ifdef FFD_ARB_TIMEOUT_EN
    assign o_err     = r_err;
`else
    // Constant 0; written against TOUT so the parameter is consumed in this build too.
    assign o_err     = (TOUT < 0);
`endif

endmodule

// File: tb/tb_ffd_bank_write_arbiter.sv
module tb_ffd_bank_write_arbiter;
    localparam int NREQ  = 4;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int TOUT  = 15;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     ack;
    logic [DEPTH-1:0]    bank_ld;
    logic [DW-1:0]       bank_d;
    logic                busy;
    logic                err;

    always #5 clk = ~clk;

    ffd_bank_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TOUT(TOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_wdata(wdata),
        .o_grant(grant), .o_ack(ack), .o_bank_ld(bank_ld), .o_bank_d(bank_d),
        .o_busy(busy), .o_err(err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    endtask

    // ---------------- reference model: requester view + round-robin pointer
    typedef struct {
        logic [NREQ-1:0]  grant;
        logic [DEPTH-1:0] ld;
        logic [DW-1:0]    d;
    } exp_t;

    exp_t            exp_q[$];
    logic [NREQ-1:0] ack_q[$];

    logic [NREQ-1:0] pend;
    logic [AW-1:0]   m_addr[NREQ];
    logic [DW-1:0]   m_data[NREQ];
    int              m_ptr;

    function automatic int model_pick(input logic [NREQ-1:0] p, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // ---------------- monitor: pops expectations when the DUT writes / acks
    exp_t            mon_e;
    logic [NREQ-1:0] mon_a;
    int              ld_cyc = -100;

    always @(negedge clk) begin
        if (!rst) begin
            if (bank_ld != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ld", 32'(bank_ld), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bank_ld", 32'(bank_ld), 32'(mon_e.ld));
                    check("bank_d", 32'(bank_d), 32'(mon_e.d));
                    check("grant_at_ld", 32'(grant), 32'(mon_e.grant));
                    ld_cyc = cyc;
                end
            end
            if (ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    mon_a = ack_q.pop_front();
                    check("ack", 32'(ack), 32'(mon_a));
                    check("ack_after_ld", cyc, ld_cyc + 1);
                end
            end
        end
    end

    // ---------------- driver helpers
    function automatic logic [31:0] all_outs();
        return 32'({grant, ack, bank_ld, bank_d, busy, err});
    endfunction

    task automatic raise(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        m_addr[i] = a;
        m_data[i] = d;
        req[i]    = 1'b1;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset(input int cycles, input logic [NREQ-1:0] rq, input bit chk);
        rst = 1'b1;
        req = rq;
        repeat (cycles) begin
            @(negedge clk);
            if (chk) check("reset_outputs", all_outs(), 32'h0);
        end
        rst   = 1'b0;
        req   = '0;
        pend  = '0;
        m_ptr = 0;
        exp_q.delete();
        ack_q.delete();
    endtask

    // One write: model predicts the owner, bench waits for grant and ack,
    // optionally corrupts the owner's data after grant, then releases.
    task automatic run_txn(input int hold, input bit scr, input logic [DW-1:0] scr_d,
                           input bit keep, output int w);
        exp_t e;
        int   n;
        w = model_pick(pend, m_ptr);
        if (w < 0) begin
            check("model_has_request", 32'(pend), 32'h1);
            return;
        end
        e.grant = NREQ'(1) << w;
        e.ld    = DEPTH'(1) << m_addr[w];
        e.d     = m_data[w];
        exp_q.push_back(e);
        ack_q.push_back(e.grant);
        m_ptr = (w + 1) % NREQ;

        n = 0;
        while (busy && n < 8) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (grant == '0 && n < 8);
        check("grant", 32'(grant), 32'(e.grant));
        check("grant_latency", n, 1);
        if (scr) begin
            wdata[w*DW +: DW] = scr_d;
            addr[w*AW +: AW]  = AW'($urandom);
            m_data[w] = scr_d;
            m_addr[w] = addr[w*AW +: AW];
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!ack[w] && n < 8);
        check("ack_seen", 32'(ack[w]), 32'h1);
        check("ack_latency", n, 2);
        repeat (hold) begin
            @(negedge clk);
            check("release_hold", 32'({grant, ack}), 32'({e.grant, {NREQ{1'b0}}}));
        end
        if (!keep) begin
            req[w]  = 1'b0;
            pend[w] = 1'b0;
        end
    endtask

    int t3_exp[5] = '{0, 1, 2, 3, 0};
    int ord[5];
    int w, last;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        addr  = '0;
        wdata = '0;
        pend  = '0;
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin m_addr[i] = '0; m_data[i] = '0; end

        // T1: reset with every requester asserted
        do_reset(2, '1, 1'b1);
        @(negedge clk);
        check("idle_after_reset", 32'({grant, busy}), 32'h0);

        // T2: single write from requester 2 to register 5
        raise(2, 3'd5, 8'hA5);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);
        // ptr now 3: with 0 and 3 pending, 3 must win
        raise(0, 3'd1, 8'h01);
        raise(3, 3'd6, 8'h06);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);
        check("t2_ptr_winner", w, 3);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);

        // T3: all four requesting, each released one cycle after its ack
        do_reset(1, '0, 1'b0);
        for (int i = 0; i < NREQ; i++) raise(i, AW'($urandom), DW'($urandom));
        for (int t = 0; t < 5; t++) begin
            if (t >= 2) raise(ord[t-2], AW'($urandom), DW'($urandom));
            run_txn(1, 1'b0, 8'h00, 1'b0, ord[t]);
        end
        for (int t = 0; t < 5; t++) check("t3_order", ord[t], t3_exp[t]);
        for (int i = 0; i < NREQ; i++) begin req[i] = 1'b0; pend[i] = 1'b0; end
        @(negedge clk);
        @(negedge clk);

        // T4: owner changes its data during LOAD; the latched value is written
        raise(m_ptr, 3'd4, 8'h11);
        run_txn(0, 1'b1, 8'h22, 1'b0, w);

        // Random traffic
        last = w;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && i != last && $urandom_range(0, 1) == 1)
                    raise(i, AW'($urandom), DW'($urandom));
            if (pend == '0) raise((last + 1) % NREQ, AW'($urandom), DW'($urandom));
            run_txn($urandom_range(0, 3), ($urandom_range(0, 3) == 0), DW'($urandom), 1'b0, w);
            last = w;
        end
        for (int i = 0; i < NREQ; i++) begin req[i] = 1'b0; pend[i] = 1'b0; end
        @(negedge clk);
        @(negedge clk);

        // T5: reset during LOAD aborts the write and clears the pointer
        do_reset(1, '0, 1'b0);
        raise(1, 3'd2, 8'h33);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);      // pointer moves to 2
        raise(0, 3'd7, 8'h44);
        @(negedge clk);
        while (busy && cyc < 100000) @(negedge clk);
        @(negedge clk);
        check("t5_grant_in_load", 32'(grant), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_outputs", all_outs(), 32'h0);
        rst  = 1'b0;
        req  = '0;
        pend = '0;
        m_ptr = 0;
        repeat (3) begin
            @(negedge clk);
            check("t5_quiet", 32'({ack, bank_ld, busy}), 32'h0);
        end
        raise(1, 3'd3, 8'h55);
        raise(3, 3'd0, 8'h66);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);
        check("t5_ptr_zero_winner", w, 1);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);

`ifdef FFD_ARB_TIMEOUT_EN
        // T6: owner never releases; arbiter gives up after TOUT cycles in RELEASE
        @(negedge clk);
        @(negedge clk);
        do_reset(1, '0, 1'b0);
        raise(1, 3'd1, 8'h77);
        raise(2, 3'd2, 8'h88);
        run_txn(0, 1'b0, 8'h00, 1'b1, w);      // ack of 1 seen, req[1] stays high
        repeat (TOUT - 1) @(negedge clk);
        check("t6_before_timeout", 32'({err, busy}), 32'h1);
        @(negedge clk);
        check("t6_timeout_idle", 32'({err, busy, grant}), 32'({1'b1, 1'b0, {NREQ{1'b0}}}));
        run_txn(0, 1'b0, 8'h00, 1'b0, w);
        check("t6_next_winner", w, 2);
        run_txn(0, 1'b0, 8'h00, 1'b0, w);      // stuck owner served again as a new request
        check("t6_rerequest_winner", w, 1);
        repeat (3) @(negedge clk);
        check("t6_err_sticky", 32'({err, busy}), 32'h2);
`else
        repeat (3) @(negedge clk);
        check("err_tied_low", 32'(err), 32'h0);
`endif

        repeat (4) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        check("final_idle", 32'({grant, busy}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
